// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port 64K x 8 VRAM between the video scanout engine
// (high priority) and the CPU bus bridge (low priority). One access is granted
// per clock. Read ownership travels down a tag pipeline that matches the VRAM
// read latency, so each returned byte is steered back to the requester that
// issued it.
//
// Optional feature macro: VRAM_ARB_STARVE_EN
//   When defined, a CPU wait counter lets the CPU take a grant away from video
//   after MAX_WAIT consecutive refused cycles. When undefined, video priority
//   is fixed.
//
// Parameters
//   READ_LATENCY  clock edges from the accept edge to valid ram_data_in_q (1..4)
//   MAX_WAIT      CPU starvation limit, used only with VRAM_ARB_STARVE_EN (1..255)
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   vid_req / vid_addr           video read request, held until vid_ack
//   vid_ack                      video granted this cycle (combinational)
//   vid_rvalid / vid_rdata       video read return pulse and held data
//   cpu_req/addr/we/wdata        CPU request, held stable until cpu_ack
//   cpu_ack                      CPU granted this cycle (combinational)
//   cpu_rvalid / cpu_rdata       CPU read return pulse and held data
//   ram_addr/data_in/write_enable  VRAM drive
//   ram_data_in_q                VRAM read data

module vram_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_rvalid,
  output logic [7:0]  vid_rdata,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data_in,
  output logic        ram_write_enable,
  input  logic [7:0]  ram_data_in_q
);

  // Elaboration-time guard on the parameter ranges.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("vram_arbiter: READ_LATENCY must be 1..4");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("vram_arbiter: MAX_WAIT must be 1..255");
  end

  logic                    starve;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_owner;
  logic [7:0]              vid_hold;
  logic [7:0]              cpu_hold;
  logic                    ret_valid;
  logic                    ret_owner;

`ifdef VRAM_ARB_STARVE_EN
  logic [7:0] wait_cnt;

  // Once the CPU has been refused MAX_WAIT times in a row it overrides video.
  assign starve = cpu_req && (wait_cnt == 8'(MAX_WAIT));

  // Count refused CPU cycles, saturating; any grant or dropped request clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (!cpu_req || cpu_ack) begin
      wait_cnt <= 8'd0;
    end else if (wait_cnt != 8'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grant: video first unless the CPU has starved; CPU takes any free cycle.
  assign vid_ack = vid_req && !starve;
  assign cpu_ack = cpu_req && !vid_ack;

  // VRAM drive follows the grant; writes are blocked while reset is high.
  always_comb begin
    ram_addr         = 16'h0000;
    ram_data_in      = 8'h00;
    ram_write_enable = 1'b0;
    if (vid_ack) begin
      ram_addr = vid_addr;
    end else if (cpu_ack) begin
      ram_addr         = cpu_addr;
      ram_data_in      = cpu_wdata;
      ram_write_enable = cpu_we && !reset;
    end
  end

  // Tag pipeline: one stage per latency edge. Stage 0 captures whether the
  // granted access will produce read data and who owns it (1 = CPU).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= vid_ack || (cpu_ack && !cpu_we);
      tag_owner[0] <= !vid_ack && cpu_ack;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  assign ret_valid  = tag_valid[READ_LATENCY-1];
  assign ret_owner  = tag_owner[READ_LATENCY-1];
  assign vid_rvalid = ret_valid && !ret_owner;
  assign cpu_rvalid = ret_valid && ret_owner;

  // During a return pulse the data comes straight from the VRAM; otherwise
  // the last returned byte is presented from the hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_hold <= 8'h00;
      cpu_hold <= 8'h00;
    end else begin
      if (vid_rvalid) vid_hold <= ram_data_in_q;
      if (cpu_rvalid) cpu_hold <= ram_data_in_q;
    end
  end

  assign vid_rdata = vid_rvalid ? ram_data_in_q : vid_hold;
  assign cpu_rdata = cpu_rvalid ? ram_data_in_q : cpu_hold;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 64K x 8 VRAM between two requesters: the video scanout engine (high priority) and the CPU bus bridge (low priority).
- Sits directly in front of the VRAM.
- Arbitrates one access per clock and drives the VRAM address, write-data and write-enable lines.
- Tracks in-flight reads through a tag pipeline and steers returned read data back to the requester that issued it.

Parameters:
- READ_LATENCY, 2: clock edges from the accept edge until VRAM read data is valid on ram_data_out; range 1..4.
- MAX_WAIT, 8: starvation limit for the CPU port; used only when VRAM_ARB_STARVE_EN is defined; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  video access request; held until accepted.
- vid_addr  in  16  video read address.
- vid_ack  out  1  video request accepted this cycle (combinational).
- vid_rvalid  out  1  one-cycle pulse: vid_rdata is valid.
- vid_rdata  out  8  video read data.
- cpu_req  in  1  CPU access request; held, with stable addr/we/wdata, until accepted.
- cpu_addr  in  16  CPU address.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata is valid (reads only).
- cpu_rdata  out  8  CPU read data.
- ram_addr  out  16  to VRAM address.
- ram_data_in  out  8  to VRAM write data.
- ram_write_enable  out  1  to VRAM write enable.
- ram_data_in_q  in  8  from VRAM data_out.

Behaviour:
- Arbitration is combinational, once per cycle:
  - vid_req high: video wins.
  - else cpu_req high: CPU wins.
  - else idle.
  - The winner's ack is high during that cycle; the access takes place at the next rising edge.
- VRAM drive by grant:
  - Video grant: ram_addr = vid_addr, ram_write_enable = 0, ram_data_in = 0.
  - CPU grant: ram_addr = cpu_addr, ram_data_in = cpu_wdata, ram_write_enable = cpu_we.
  - Idle: ram_addr = 0, ram_data_in = 0, ram_write_enable = 0.
- Read-return tag pipeline:
  - READ_LATENCY stages, each holding {valid, owner}.
  - Stage 0 is loaded at the accept edge with valid = 1 for a video grant or a CPU read, 0 otherwise; owner is 0 = video, 1 = CPU.
  - Stages shift every clock.
- Read return:
  - When the last stage is valid, the owning requester's rvalid is high that cycle.
  - That requester's rdata equals ram_data_in_q.
  - The non-owner's rvalid is 0.
- Ack-to-rvalid latency is exactly READ_LATENCY cycles (ack in cycle N, rvalid in cycle N+READ_LATENCY).
- Throughput: back-to-back grants, one per cycle; reads return in issue order with no bubbles.
- cpu_rdata and vid_rdata hold their last returned value between pulses.
- CPU writes produce no rvalid. A write accepted the cycle after a read to the same address does not corrupt that read's return.
- Reset (asynchronous, active-high):
  - All tag stages cleared; starvation counter cleared.
  - vid_rvalid = cpu_rvalid = 0; vid_rdata = cpu_rdata = 0.
  - Reads in flight at reset are dropped and never return an rvalid.
  - Acks and VRAM drive remain combinational; they follow the req inputs during reset, but the write is suppressed: ram_write_enable = 0 while reset is high.
- Simultaneous requests without the optional feature: video always wins; the CPU waits indefinitely under continuous video load.

Optional Feature:
- Macro: VRAM_ARB_STARVE_EN.
- Defined:
  - An 8-bit wait counter increments each cycle that cpu_req = 1 and cpu_ack = 0, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT, the CPU wins arbitration over video that cycle; vid_ack = 0 and video retries.
  - The counter clears on cpu_ack, when cpu_req is low, and on reset.
- Undefined: no counter exists; fixed video priority.

Test Plan:
- Preload 0x1234 = 0xA5 via a CPU write; CPU read of 0x1234 -> cpu_ack in cycle N, cpu_rvalid = 1 with cpu_rdata = 0xA5 in cycle N+2; vid_rvalid stays 0.
- vid_req and cpu_req both high for 1 cycle, then cpu_req held -> vid_ack first; cpu_ack the next cycle; returns arrive in order, video then CPU, on consecutive cycles.
- Video reads 0x0000..0x0003 back-to-back (data 0x10..0x13) -> four consecutive vid_rvalid pulses carrying 0x10, 0x11, 0x12, 0x13.
- CPU write 0x8001 = 0x3C, then a video read of 0x8001 -> vid_rdata = 0x3C (exercises the upper bank).
- Reset asserted 1 cycle after a CPU read ack -> no cpu_rvalid at any later cycle; all outputs at reset values.
- VRAM_ARB_STARVE_EN defined, MAX_WAIT = 8, vid_req held high, cpu_req raised -> cpu_ack is asserted on exactly the 9th cycle after cpu_req rises (8 waiting cycles); undefined -> cpu_ack never asserted.
